// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit: a shift-add multiplier and a radix-2 restoring divider share one accumulator.
// Define MDU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle full-width product.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, a_d;       // |src1|: multiplicand / dividend magnitude
  logic [WIDTH-1:0]       b_q, b_d;       // |src2|: multiplier / divisor magnitude
  logic                   neg_q, neg_d;   // operand signs differ (signed ops only)
  logic                   sa_q, sa_d;     // dividend negative (signed ops only)
  logic [2*WIDTH-1:0]     acc_q, acc_d;   // mul: {hi, multiplier/lo}; div: {remainder, quotient}
  logic [WIDTH-1:0]       result_q, result_d;

  function automatic logic is_mul(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHU);
  endfunction

  function automatic logic [CW-1:0] last_cnt(input logic [2:0] o);
    if (o == 3'd7) return CW'(1);
`ifdef MDU_FAST_MUL_EN
    if (is_mul(o)) return CW'(1);
`endif
    return CW'(WIDTH);
  endfunction

  logic               sgn_in, sa_in, sb_in;
  logic [WIDTH:0]     mul_sum, div_rs, div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    sgn_in    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
    sa_in     = sgn_in & src1[WIDTH-1];
    sb_in     = sgn_in & src2[WIDTH-1];

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rs    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_rs - {1'b0, b_q};

    prod = ((op_q == OP_MULH) && neg_q) ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    // Divide by zero leaves quotient all ones and remainder = |dividend|; only the quotient sign fix must be skipped.
    if (b_q == '0) quo = '1;
    else if (neg_q) quo = -quo;
    if (sa_q) rem = -rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = op;
          a_d      = sa_in ? -src1 : src1;
          b_d      = sb_in ? -src2 : src2;
          sa_d     = sa_in;
          neg_d    = sa_in ^ sb_in;
          acc_d    = is_mul(op) ? {{WIDTH{1'b0}}, (sb_in ? -src2 : src2)}
                                : {{WIDTH{1'b0}}, (sa_in ? -src1 : src1)};
          cnt_d    = '0;
          result_d = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cnt_q == last_cnt(op_q)) begin
          // One extra cycle after the iterations applies sign correction and selects the result.
          case (op_q)
            OP_MUL:                result_d = prod[WIDTH-1:0];
            OP_MULH, OP_MULHU:     result_d = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:       result_d = quo;
            OP_MOD, OP_MODU:       result_d = rem;
            default:               result_d = '0;
          endcase
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_mul(op_q)) begin
`ifdef MDU_FAST_MUL_EN
            acc_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
          end else if (op_q != 3'd7) begin
            if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_d = {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? result_q : '0;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32 with hand-computed expected values.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        in_ready, out_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns edges from accept to out_valid.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit consume, output int lat, output logic [31:0] res);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  int          lat;
  logic [31:0] res;
  int          seen;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src1 = '0; src2 = '0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, lat, res);
    chk("div_neg7_2", res, 32'hFFFFFFFD);
    chk("div_lat", lat, 33);
    run(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, lat, res);
    chk("mod_neg7_2", res, 32'hFFFFFFFF);
    run(3'd5, 32'h12345678, 32'd0, 1'b1, lat, res);
    chk("divu_by0", res, 32'hFFFFFFFF);
    chk("divu_by0_lat", lat, 33);
    run(3'd6, 32'h12345678, 32'd0, 1'b1, lat, res);
    chk("modu_by0", res, 32'h12345678);
    run(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res);
    chk("div_ovf", res, 32'h80000000);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res);
    chk("mod_ovf", res, 32'h00000000);
    run(3'd3, 32'hFFFFFFFB, 32'd0, 1'b1, lat, res);
    chk("div_neg_by0", res, 32'hFFFFFFFF);
    run(3'd4, 32'hFFFFFFFB, 32'd0, 1'b1, lat, res);
    chk("mod_neg_by0", res, 32'hFFFFFFFB);
    run(3'd5, 32'd100, 32'd7, 1'b1, lat, res);
    chk("divu_100_7", res, 32'd14);
    run(3'd6, 32'd100, 32'd7, 1'b1, lat, res);
    chk("modu_100_7", res, 32'd2);

    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res);
    chk("mulh_m1", res, 32'h00000000);
    chk("mul_lat", lat, MUL_LAT);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res);
    chk("mulhu_ff", res, 32'hFFFFFFFE);
    run(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res);
    chk("mul_ff", res, 32'h00000001);
    run(3'd0, 32'd12345, 32'd6789, 1'b1, lat, res);
    chk("mul_small", res, 32'h04FED79D);
    run(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, lat, res);
    chk("mulh_neg", res, 32'hFFFFFFFF);
    run(3'd7, 32'h1234, 32'h5678, 1'b1, lat, res);
    chk("op7_res", res, 32'd0);
    chk("op7_lat", lat, 2);

    // Backpressure: result held while out_ready low, pending request waits.
    run(3'd5, 32'd100, 32'd7, 1'b0, lat, res);
    in_valid = 1'b1; op = 3'd6; src1 = 32'd100; src2 = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'd14);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_consumed_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_after", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    // Flush 10 cycles into a DIVU.
    in_valid = 1'b1; op = 3'd5; src1 = 32'hDEADBEEF; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("flush_no_valid", seen, 0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_blocks_accept", {31'd0, in_ready}, 32'd1);

    // Reset while a result waits in DONE.
    run(3'd0, 32'd6, 32'd7, 1'b0, lat, res);
    chk("pre_reset_res", res, 32'd42);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_done_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done_result", result, 32'd0);
    chk("rst_done_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_done_ready_after", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  abort in-flight operation.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  operation: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 MOD, 5 DIVU, 6 MODU, 7 reserved.
REQ-008 SHALL have port src1  input  WIDTH  multiplicand / dividend (rj).
REQ-009 SHALL have port src2  input  WIDTH  multiplier / divisor (rk).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  operation result.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept a request when in_valid & in_ready & ~flush, latching op, src1, src2 and entering CALC.
REQ-015 SHALL compute divides with a radix-2 restoring iterator, one quotient bit per cycle, exactly WIDTH CALC cycles.
REQ-016 SHALL compute signed divides on magnitudes, then negate quotient if signs differ and remainder to take dividend sign.
REQ-017 SHALL assert out_valid exactly N+1 cycles after the accepting edge, N = CALC cycle count for the op.
REQ-018 SHALL hold result and out_valid stable in DONE until out_ready is 1, then return to IDLE next edge.
REQ-019 SHALL keep in_ready low in DONE; no back-to-back accept in the cycle a result is consumed.
REQ-020 SHALL, for divisor 0: quotient all ones, remainder = src1, full WIDTH-cycle latency.
REQ-021 SHALL, for DIV with src1 = signed minimum and src2 = -1: quotient = signed minimum, MOD result 0.
REQ-022 SHALL return MUL low WIDTH bits, MULH high WIDTH bits of signed product, MULHU high bits of unsigned product.
REQ-023 SHALL, for op 7, spend 1 CALC cycle and return 0.
REQ-024 SHALL, when flush is 1 in any state, enter IDLE next edge, discarding any result; flush overrides in_valid.
REQ-025 SHALL drive result 0 whenever out_valid is 0.

Reset
REQ-026 SHALL, on reset high at a clock edge, enter IDLE and clear all iteration registers; reset overrides flush and in_valid.
REQ-027 SHALL present in_ready=0 while reset is high and out_valid=0, result=0 in the first cycle after reset deasserts, with in_ready=1.
REQ-028 SHALL abort any operation in CALC or DONE on reset with no result emitted.

Configuration
REQ-029 SHALL honour macro MDU_FAST_MUL_EN: when defined, MUL/MULH/MULHU use a single-cycle full-width product (1 CALC cycle).
REQ-030 SHALL, without MDU_FAST_MUL_EN, compute multiplies with a shift-add iterator over 2*WIDTH-bit accumulator, WIDTH CALC cycles, identical results.
REQ-031 SHALL leave divide latency and all handshake behaviour unaffected by MDU_FAST_MUL_EN.

Verification (WIDTH=32)
REQ-032 SHALL cover: DIV src1=-7 (0xFFFFFFF9), src2=2 -> result 0xFFFFFFFD, out_valid 33 cycles after accept; MOD same operands -> 0xFFFFFFFF.
REQ-033 SHALL cover: DIVU src1=0x12345678, src2=0 -> 0xFFFFFFFF; MODU same -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-034 SHALL cover: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MUL -> 0x00000001; latency 2 with MDU_FAST_MUL_EN, 33 without.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready 0, pulse accepted only after out_ready.
REQ-036 SHALL cover: flush asserted 10 cycles into a DIVU -> IDLE next edge, no out_valid; flush with in_valid same cycle -> no accept.
REQ-037 SHALL cover: reset asserted in DONE -> next cycle out_valid=0, result=0; in_ready=1 once reset deasserts.
